// File: rtl/seq_pkg.sv
// Shared definitions for the music_sequencer playback controller:
// FSM state encoding, reserved note/duration codes and the ROM word layout.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4
  } seq_state_t;

  localparam int unsigned REST    = 0;
  localparam int unsigned END_DUR = 0;

  // ROM word is {note, dur}: dur sits in the low bits, note directly above it.
  localparam int unsigned DUR_LSB = 0;

  function automatic int unsigned note_lsb(input int unsigned dur_bits);
    return DUR_LSB + dur_bits;
  endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Control, song-ROM and tone-generator signals of music_sequencer.
// master = the sequencer itself, slave = buttons/ROM/tone generator side.
interface music_sequencer_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned NOTE_BITS = 5,
  parameter int unsigned DUR_BITS  = 4
);

  logic                          play;
  logic                          pause;
  logic                          stop;
  logic [ADDR_BITS-1:0]          rom_addr;
  logic [NOTE_BITS+DUR_BITS-1:0] rom_data;
  logic [NOTE_BITS-1:0]          note_out;
  logic                          beat;
  logic                          playing;
  logic                          done;

  modport master (
    input  play, pause, stop, rom_data,
    output rom_addr, note_out, beat, playing, done
  );

  modport slave (
    output play, pause, stop, rom_data,
    input  rom_addr, note_out, beat, playing, done
  );

endinterface

// File: rtl/seq_tick_div.sv
// Beat-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count. Synchronous clear wins over enable. TICK_DIV must be >= 2.
module seq_tick_div #(
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic clk,
  input  logic r,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned    CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/music_sequencer.sv
// Song-ROM playback controller with play/pause/stop. Define SEQ_LOOP_EN to
// restart the song from address 0 at the end marker instead of returning to IDLE.
module music_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 6250000,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned NOTE_BITS = 5,
  parameter int unsigned DUR_BITS  = 4
) (
  input logic               clk,
  input logic               r,
  music_sequencer_if.master bus
);

  localparam int unsigned          NOTE_LSB  = note_lsb(DUR_BITS);
  localparam logic [NOTE_BITS-1:0] REST_NOTE = NOTE_BITS'(REST);
  localparam logic [DUR_BITS-1:0]  END_MARK  = DUR_BITS'(END_DUR);
  localparam logic [DUR_BITS-1:0]  LAST_TICK = DUR_BITS'(1);

  seq_state_t           state;
  logic [ADDR_BITS-1:0] rom_addr;
  logic [NOTE_BITS-1:0] note_out;
  logic [NOTE_BITS-1:0] held_note;
  logic [NOTE_BITS-1:0] rom_note;
  logic [DUR_BITS-1:0]  dur_cnt;
  logic [DUR_BITS-1:0]  rom_dur;
  logic                 playing;
  logic                 done;
  logic                 tick;
  logic                 div_en;
  logic                 div_clr;

  assign rom_note = bus.rom_data[NOTE_LSB +: NOTE_BITS];
  assign rom_dur  = bus.rom_data[DUR_LSB +: DUR_BITS];

  // Prescaler runs only in PLAY, holds its count through PAUSE, and restarts
  // from 0 in every other state so each note's first beat is TICK_DIV away.
  assign div_en  = (state == S_PLAY);
  assign div_clr = bus.stop || !(state inside {S_PLAY, S_PAUSE});

  seq_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk (clk),
    .r   (r),
    .en  (div_en),
    .clr (div_clr),
    .tc  (tick)
  );

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      note_out  <= REST_NOTE;
      held_note <= REST_NOTE;
      dur_cnt   <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.stop) begin
        state    <= S_IDLE;
        rom_addr <= '0;
        note_out <= REST_NOTE;
        dur_cnt  <= '0;
        playing  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.play) begin
              state   <= S_FETCH;
              playing <= 1'b1;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            if (rom_dur == END_MARK) begin
              done     <= 1'b1;
              rom_addr <= '0;
`ifdef SEQ_LOOP_EN
              state    <= S_FETCH;
`else
              state    <= S_IDLE;
              note_out <= REST_NOTE;
              playing  <= 1'b0;
`endif
            end else begin
              note_out  <= rom_note;
              held_note <= rom_note;
              dur_cnt   <= rom_dur;
              state     <= S_PLAY;
            end
          end
          S_PLAY: begin
            // The final tick ends the note; a pause landing on it is dropped
            // because the controller is then already heading to FETCH.
            if (tick && dur_cnt == LAST_TICK) begin
              rom_addr <= rom_addr + ADDR_BITS'(1);
              dur_cnt  <= '0;
              state    <= S_FETCH;
            end else begin
              if (tick) dur_cnt <= dur_cnt - DUR_BITS'(1);
              if (bus.pause) begin
                state    <= S_PAUSE;
                note_out <= REST_NOTE;
                playing  <= 1'b0;
              end
            end
          end
          S_PAUSE: begin
            if (bus.play) begin
              state    <= S_PLAY;
              note_out <= held_note;
              playing  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr = rom_addr;
  assign bus.note_out = note_out;
  assign bus.beat     = tick;
  assign bus.playing  = playing;
  assign bus.done     = done;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with TICK_DIV=4 and a 4-entry song ROM.
module tb_music_sequencer;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned ADDR_BITS = 2;
  localparam int unsigned NOTE_BITS = 5;
  localparam int unsigned DUR_BITS  = 4;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct packed {
    logic [NOTE_BITS-1:0] note;
    logic [ADDR_BITS-1:0] addr;
    logic                 beat;
    logic                 done;
    logic                 playing;
  } obs_t;

  logic clk = 1'b0;
  logic r   = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [NOTE_BITS+DUR_BITS-1:0] rom [4];
  obs_t obs;

  music_sequencer_if #(.ADDR_BITS(ADDR_BITS), .NOTE_BITS(NOTE_BITS), .DUR_BITS(DUR_BITS)) bus ();

  music_sequencer #(
    .TICK_DIV (TICK_DIV),
    .ADDR_BITS(ADDR_BITS),
    .NOTE_BITS(NOTE_BITS),
    .DUR_BITS (DUR_BITS)
  ) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Registered song ROM: data valid one cycle after the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  assign obs = {bus.note_out, bus.rom_addr, bus.beat, bus.done, bus.playing};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    obs_t e;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    r = 1'b1;
    step(2);
    e = '0;
    n_total++;
    if (obs !== e) $display("FAIL reset_held got note=%0d addr=%0d beat=%b done=%b playing=%b want all zero",
                            obs.note, obs.addr, obs.beat, obs.done, obs.playing);
    else n_pass++;
    r = 1'b0;
    step(1);
    #1;
    n_total++;
    if (obs !== e) $display("FAIL reset_released got note=%0d addr=%0d beat=%b done=%b playing=%b want all zero",
                            obs.note, obs.addr, obs.beat, obs.done, obs.playing);
    else n_pass++;
  endtask

  task automatic test_basic();
    obs_t e;
    rom[0] = {5'd5, 4'd2};
    rom[1] = {5'd7, 4'd1};
    rom[2] = '0;
    rom[3] = '0;
    for (int c = 0; c <= 20; c++) begin
      bus.play = (c == 0);
      #1;
      e.note    = 5'(c < 3 ? 0 : c <= 12 ? 5 : c <= 18 ? 7 : (LOOP ? 7 : 0));
      e.addr    = 2'(c <= 10 ? 0 : c <= 16 ? 1 : c <= 18 ? 2 : 0);
      e.beat    = (c == 6 || c == 10 || c == 16);
      e.done    = (c == 19);
      e.playing = (c >= 1 && c <= 18) || (LOOP && c >= 19);
      n_total++;
      if (obs !== e) $display("FAIL basic c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.play = 1'b0;
    pulse_stop();
  endtask

  task automatic test_pause();
    obs_t e;
    rom[0] = {5'd9, 4'd3};
    rom[1] = {5'd4, 4'd1};
    for (int c = 0; c <= 25; c++) begin
      bus.play  = (c == 0 || c == 14);
      bus.pause = (c == 4);
      #1;
      e.note    = 5'(c < 3 ? 0 : c <= 4 ? 9 : c <= 14 ? 0 : 9);
      e.addr    = 2'(c == 25 ? 1 : 0);
      e.beat    = (c == 16 || c == 20 || c == 24);
      e.done    = 1'b0;
      e.playing = (c >= 1 && c <= 4) || c >= 15;
      n_total++;
      if (obs !== e) $display("FAIL pause c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.play  = 1'b0;
    bus.pause = 1'b0;
    pulse_stop();
  endtask

  task automatic test_stop();
    obs_t e;
    rom[0] = {5'd5, 4'd1};
    rom[1] = {5'd7, 4'd1};
    rom[2] = '0;
    // stop while LOAD of the second note
    for (int c = 0; c <= 10; c++) begin
      bus.play = (c == 0);
      bus.stop = (c == 8);
      #1;
      e.note    = 5'(c < 3 ? 0 : c <= 8 ? 5 : 0);
      e.addr    = 2'(c >= 7 && c <= 8 ? 1 : 0);
      e.beat    = (c == 6);
      e.done    = 1'b0;
      e.playing = (c >= 1 && c <= 8);
      n_total++;
      if (obs !== e) $display("FAIL stop_load c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    // stop while PAUSE of the second note
    for (int c = 0; c <= 13; c++) begin
      bus.play  = (c == 0);
      bus.pause = (c == 10);
      bus.stop  = (c == 12);
      #1;
      e.note    = 5'(c < 3 ? 0 : c <= 8 ? 5 : c <= 10 ? 7 : 0);
      e.addr    = 2'(c >= 7 && c <= 12 ? 1 : 0);
      e.beat    = (c == 6);
      e.done    = 1'b0;
      e.playing = (c >= 1 && c <= 10);
      n_total++;
      if (obs !== e) $display("FAIL stop_pause c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    // restart after stop begins at address 0 with fresh counters
    for (int c = 0; c <= 6; c++) begin
      bus.play = (c == 0);
      #1;
      e.note    = 5'(c < 3 ? 0 : 5);
      e.addr    = '0;
      e.beat    = (c == 6);
      e.done    = 1'b0;
      e.playing = (c >= 1);
      n_total++;
      if (obs !== e) $display("FAIL stop_restart c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.play = 1'b0;
    pulse_stop();
  endtask

  task automatic test_combined();
    obs_t e;
    rom[0] = {5'd5, 4'd2};
    // play+pause+stop together in PLAY: stop wins, next play goes through FETCH
    for (int c = 0; c <= 8; c++) begin
      bus.play  = (c == 0 || c == 4 || c == 5);
      bus.pause = (c == 4);
      bus.stop  = (c == 4);
      #1;
      e.note    = 5'(c < 3 ? 0 : c <= 4 ? 5 : c <= 7 ? 0 : 5);
      e.addr    = '0;
      e.beat    = 1'b0;
      e.done    = 1'b0;
      e.playing = (c >= 1 && c <= 4) || c >= 6;
      n_total++;
      if (obs !== e) $display("FAIL all_three c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.play  = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    pulse_stop();
    // pause+play together in PLAY: pause wins, count resumes where it stopped
    for (int c = 0; c <= 8; c++) begin
      bus.play  = (c == 0 || c == 4 || c == 6);
      bus.pause = (c == 4);
      #1;
      e.note    = 5'(c < 3 ? 0 : c <= 4 ? 5 : c <= 6 ? 0 : 5);
      e.addr    = '0;
      e.beat    = (c == 8);
      e.done    = 1'b0;
      e.playing = (c >= 1 && c <= 4) || c >= 7;
      n_total++;
      if (obs !== e) $display("FAIL pause_play c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.play  = 1'b0;
    bus.pause = 1'b0;
    pulse_stop();
  endtask

  task automatic test_wrap();
    obs_t e;
    for (int i = 0; i < 4; i++) rom[i] = {5'(i + 1), 4'd1};
    for (int c = 0; c <= 33; c++) begin
      bus.play = (c == 0);
      #1;
      e.note    = 5'(c < 3 ? 0 : ((c - 3) / 6) % 4 + 1);
      e.addr    = 2'(c < 7 ? 0 : ((c - 7) / 6 + 1) % 4);
      e.beat    = (c >= 6 && (c - 6) % 6 == 0);
      e.done    = 1'b0;
      e.playing = (c >= 1);
      n_total++;
      if (obs !== e) $display("FAIL wrap c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.play = 1'b0;
    pulse_stop();
  endtask

  task automatic test_async_reset();
    obs_t e;
    rom[0] = {5'd5, 4'd1};
    rom[1] = {5'd7, 4'd2};
    rom[2] = '0;
    bus.play = 1'b1;
    step(1);
    bus.play = 1'b0;
    step(9);
    #1;
    e = '{note: 5'd7, addr: 2'd1, beat: 1'b0, done: 1'b0, playing: 1'b1};
    n_total++;
    if (obs !== e) $display("FAIL areset_before got note=%0d addr=%0d playing=%b want note=7 addr=1 playing=1",
                            obs.note, obs.addr, obs.playing);
    else n_pass++;
    #2;
    r = 1'b1;
    #1;
    e = '0;
    n_total++;
    if (obs !== e) $display("FAIL areset_immediate got note=%0d addr=%0d beat=%b done=%b playing=%b want all zero",
                            obs.note, obs.addr, obs.beat, obs.done, obs.playing);
    else n_pass++;
    #7;
    r = 1'b0;
    step(1);
    for (int c = 0; c <= 6; c++) begin
      bus.play = (c == 0);
      #1;
      e.note    = 5'(c < 3 ? 0 : 5);
      e.addr    = '0;
      e.beat    = (c == 6);
      e.done    = 1'b0;
      e.playing = (c >= 1);
      n_total++;
      if (obs !== e) $display("FAIL areset_restart c%0d got note=%0d addr=%0d beat=%b done=%b playing=%b want note=%0d addr=%0d beat=%b done=%b playing=%b",
                              c, obs.note, obs.addr, obs.beat, obs.done, obs.playing, e.note, e.addr, e.beat, e.done, e.playing);
      else n_pass++;
      step(1);
    end
    bus.play = 1'b0;
    pulse_stop();
  endtask

  initial begin
    bus.play  = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    test_reset();
    test_basic();
    test_pause();
    test_stop();
    test_combined();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Playback controller for the music player. Walks a song ROM one note at a time, holds each note code on its output for the note's duration in beat ticks, and handles play/pause/stop from the debounced front-panel buttons. Sits between the button conditioning logic and the tone generator. It owns the song-ROM address and the note-duration/tempo counters.

## Interface
- TICK_DIV, 6250000: clocks per beat tick (16 ticks/s at 100 MHz); must be ≥ 2
- ADDR_BITS, 8: song ROM address width
- NOTE_BITS, 5: note code width; code 0 = rest/silence
- DUR_BITS, 4: note duration field width, in ticks; duration 0 = end-of-song marker
- clk  in  1  system clock; all logic on rising edge
- r  in  1  reset, asynchronous, active-high
- play  in  1  single-cycle pulse: start from IDLE, or resume from PAUSE
- pause  in  1  single-cycle pulse: freeze playback (honoured in PLAY only)
- stop  in  1  single-cycle pulse: abort to IDLE from any state
- rom_addr  out  ADDR_BITS  song ROM address
- rom_data  in  NOTE_BITS+DUR_BITS  ROM word {note, dur}, registered ROM, valid 1 cycle after rom_addr
- note_out  out  NOTE_BITS  note code to tone generator
- beat  out  1  one-cycle pulse on every tick while in PLAY
- playing  out  1  high in FETCH, LOAD, PLAY
- done  out  1  one-cycle pulse when the end marker is reached

## Operation
- Reset values: state IDLE, rom_addr 0, note_out 0, beat 0, playing 0, done 0, prescaler 0, dur_cnt 0.
- Input priority when several pulses coincide: stop > pause > play.
- IDLE: rom_addr held at 0, note_out 0. play → FETCH. pause ignored.
- FETCH: rom_addr stable; note_out keeps its previous value (no glitch between notes) → LOAD next cycle.
- LOAD: sample rom_data.
  - If dur ≠ 0: note_out ← note, dur_cnt ← dur, prescaler ← 0 → PLAY.
  - If dur = 0 (end marker): done pulse, then see Configuration.
- PLAY: prescaler counts 0..TICK_DIV-1 and wraps. At the terminal count: beat pulses and dur_cnt decrements. When the tick fires with dur_cnt = 1: rom_addr ← rom_addr+1 → FETCH. pause → PAUSE.
- PAUSE: prescaler, dur_cnt and rom_addr frozen; note_out forced 0. play → PLAY, restoring the held note code (kept in an internal register) and continuing the count exactly where it stopped.
- stop in any state: next cycle IDLE, rom_addr 0, note_out 0, counters 0. No done pulse.
- pause in FETCH/LOAD/IDLE is ignored. play in FETCH/LOAD/PLAY is ignored.
- rom_addr increments modulo 2^ADDR_BITS, so 2^ADDR_BITS-1 wraps to 0.
- A ROM with no end marker therefore plays forever.

## Timing
- play pulse in cycle 0 → FETCH in cycle 1 → LOAD in cycle 2 → PLAY with note_out valid in cycle 3.
- A note of duration d occupies d·TICK_DIV cycles in PLAY.
- Note-to-note period is d·TICK_DIV+2 cycles; the 2 extra cycles are FETCH+LOAD, during which the old note is held.
- The first beat of a note comes TICK_DIV cycles after entering PLAY.
- Pause/resume: the state changes on the cycle after the pulse. Paused cycles do not count.
- r asserted mid-note: all outputs reach their reset values immediately (asynchronous), with no done pulse.

## Configuration
- SEQ_LOOP_EN defined: the end marker in LOAD pulses done, sets rom_addr ← 0, and goes to FETCH. The song repeats and playing stays high.
- SEQ_LOOP_EN undefined: the end marker pulses done, then goes to IDLE with rom_addr 0, note_out 0 and playing 0.

## Structure
- Shared package/header seq_pkg holds:
  - state encoding (IDLE, FETCH, LOAD, PLAY, PAUSE, 3 bits)
  - the REST note code (0)
  - the END_DUR marker value (0)
  - field offsets for {note, dur} in the ROM word
- One sub-module, seq_tick_div: the TICK_DIV prescaler with enable and synchronous clear, producing a terminal-count pulse. The FSM, dur_cnt and rom_addr counters stay in music_sequencer.

## Test plan
Bench uses TICK_DIV=4.
- ROM {5,2},{7,1},{0,0}, play at cycle 0 → note_out 5 in cycles 3–10, then 7 in cycles 13–16. beat pulses at cycles 6, 10, 16. done pulses in LOAD at cycle 19. Then IDLE (loop off) or rom_addr 0 with FETCH (SEQ_LOOP_EN).
- pause 2 cycles into a dur-3 note, hold for 10 cycles, then play → note_out 0 while paused. Total PLAY cycles for the note are still 12 and the note resumes with the same code.
- stop during LOAD, and separately during PAUSE → IDLE next cycle with rom_addr 0, note_out 0, playing 0, no done pulse.
- play, pause and stop pulsed in the same cycle while in PLAY → IDLE. pause and play together in PLAY → PAUSE.
- ROM with no end marker, ADDR_BITS=2 → rom_addr sequence 0,1,2,3,0 and playback continues.
- Assert r for 1 cycle mid-note between clock edges → outputs go to reset values at once. A subsequent play restarts at address 0.
